aes_loopback_checker: RTL
=========================

// Module: aes_loopback_checker
// PURPOSE
//  Self-check stage downstream of aes_inv_chiper.
//  Taps plaintext accepted by aes_encryption and buffers it in an internal FIFO.
//  Compares each beat from the inverse cipher output against the oldest buffered beat.
//  Exposes pass/fail/packet counters, sticky error flags and first-failure capture for the ILA.
//  Purely passive on both streams: drives no ready.
// PARAMETERS
//  TDATA_WIDTH  128  stream data width
//  FIFO_DEPTH   32   reference FIFO entries; power of 2, >= 16 (covers 14-round pipeline depth)
//  CNT_WIDTH    32   width of the pass/fail/packet counters
// PORTS
//  clk             in   1                    single design clock
//  rst             in   1                    synchronous, active-high reset
//  ref_tdata       in   TDATA_WIDTH          plaintext tap (encryptor input tdata)
//  ref_tvalid      in   1                    plaintext tap tvalid
//  ref_tready      in   1                    plaintext tap tready (monitored only)
//  ref_tlast       in   1                    plaintext tap tlast
//  dut_tdata       in   TDATA_WIDTH          inverse-cipher output tdata
//  dut_tvalid      in   1                    inverse-cipher output tvalid (sink always ready)
//  dut_tlast       in   1                    inverse-cipher output tlast
//  clear           in   1                    sync clear of counters, flags, capture and FSM; FIFO kept
//  pass_cnt        out  CNT_WIDTH            beats matching data and tlast
//  fail_cnt        out  CNT_WIDTH            beats failing any check
//  pkt_cnt         out  CNT_WIDTH            passing beats with dut_tlast=1
//  fifo_level      out  $clog2(FIFO_DEPTH)+1 entries currently buffered
//  err_mismatch    out  1                    sticky: data mismatch seen
//  err_tlast       out  1                    sticky: tlast mismatch seen
//  err_overflow    out  1                    sticky: push attempted while full
//  err_underflow   out  1                    sticky: dut beat arrived with FIFO empty
//  first_fail_exp  out  TDATA_WIDTH          expected data of first failing beat
//  first_fail_got  out  TDATA_WIDTH          received data of first failing beat
//  state_o         out  2                    FSM state: 0 IDLE, 1 ACTIVE, 2 FAIL
// BEHAVIOUR
//  Reset:
//   - all outputs are 0; FIFO is empty; state is IDLE.
//   - rst overrides clear.
//  FIFO:
//   - push = ref_tvalid & ref_tready; entry is {ref_tlast, ref_tdata}.
//   - pop = dut_tvalid & (level != 0).
//   - No bypass: pop only sees entries present at the start of the cycle.
//   - Push and pop in the same cycle are legal at any level, including full; level is unchanged.
//   - Push while full with no pop: beat dropped, err_overflow set.
//  Compare:
//   - Registered, 1-cycle latency: counters, flags and capture update in the cycle after the dut beat.
//   - Pass: data equal and tlast equal. pass_cnt+1; pkt_cnt+1 if dut_tlast=1.
//   - Data differs: fail_cnt+1 and err_mismatch set.
//   - Data equal, tlast differs: fail_cnt+1 and err_tlast set.
//   - dut_tvalid with FIFO empty: fail_cnt+1, err_underflow set, expected value taken as 0.
//   - A simultaneous push still completes.
//  first_fail_*: loaded only on a failure while fail_cnt==0, then held until clear or rst.
//  Counters saturate at all-ones and never wrap.
//  clear: same-cycle compare results are discarded; FIFO contents and level are preserved.
//  FSM transitions:
//   - IDLE   -> ACTIVE  when level becomes nonzero
//   - ACTIVE -> IDLE    when level returns to 0
//   - IDLE/ACTIVE -> FAIL on any error flag being set
//   - FAIL   -> IDLE/ACTIVE on clear only (chosen by level)
//  Sticky flags clear only on rst or clear.
// TESTING
//  T1 ramp: push 0x00..01 to 0x00..10 (tlast on the 16th beat); replay identical on dut 14 cycles later.
//     Expect pass_cnt=16, pkt_cnt=1, fail_cnt=0, state IDLE.
//  T2 corruption: same as T1 but dut beat 5 has bit 0 flipped.
//     Expect fail_cnt=1, err_mismatch=1, first_fail_exp=0x..05, first_fail_got=0x..04, state FAIL.
//  T3 tlast: dut tlast asserted on beat 8 instead of 16.
//     Expect err_tlast=1, fail_cnt=2, pkt_cnt=0.
//  T4 overflow: 33 pushes with no dut beats.
//     Expect level=32, err_overflow=1, 33rd beat dropped.
//     Then push+pop at full: level stays 32.
//  T5 underflow: dut_tvalid with empty FIFO and a same-cycle push.
//     Expect err_underflow=1, fail_cnt=1, level=1.
//  T6 clear/reset: clear during T2's failing cycle -> fail_cnt=0, flags 0, FIFO intact.
//     rst mid-stream -> all outputs 0, level 0.

Source files
------------

// File: rtl/aes_loopback_checker.sv
// Passive loopback checker: buffers plaintext accepted by the encryptor and compares it
// beat-for-beat against the inverse-cipher output, keeping counters, sticky flags and first-failure capture.
module aes_loopback_checker #(
    parameter int TDATA_WIDTH = 128,
    parameter int FIFO_DEPTH  = 32,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [TDATA_WIDTH-1:0]        ref_tdata,
    input  logic                          ref_tvalid,
    input  logic                          ref_tready,
    input  logic                          ref_tlast,
    input  logic [TDATA_WIDTH-1:0]        dut_tdata,
    input  logic                          dut_tvalid,
    input  logic                          dut_tlast,
    input  logic                          clear,
    output logic [CNT_WIDTH-1:0]          pass_cnt,
    output logic [CNT_WIDTH-1:0]          fail_cnt,
    output logic [CNT_WIDTH-1:0]          pkt_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          err_mismatch,
    output logic                          err_tlast,
    output logic                          err_overflow,
    output logic                          err_underflow,
    output logic [TDATA_WIDTH-1:0]        first_fail_exp,
    output logic [TDATA_WIDTH-1:0]        first_fail_got,
    output logic [1:0]                    state_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CNT_PASS = 0;
    localparam int CNT_FAIL = 1;
    localparam int CNT_PKT  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FAIL   = 2'd2
    } state_t;

    // Reference FIFO storage: {tlast, tdata}
    logic [TDATA_WIDTH:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;

    logic                   push_req, push, pop;
    logic                   fifo_empty, fifo_full;
    logic                   overflow_evt, underflow_evt;
    logic [TDATA_WIDTH:0]   head;
    logic [TDATA_WIDTH-1:0] exp_data;
    logic                   exp_last;
    logic                   data_ok, last_ok;
    logic                   beat_pass, beat_mismatch, beat_tlast, beat_fail;

    logic [2:0]                 cnt_inc;
    logic [2:0][CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [3:0]                 err_q, err_d, err_evt;
    logic [TDATA_WIDTH-1:0]     ff_exp_q, ff_exp_d;
    logic [TDATA_WIDTH-1:0]     ff_got_q, ff_got_d;
    state_t                     state_q, state_d;

    assign fifo_empty    = (level_q == '0);
    assign fifo_full     = (level_q == LW'(FIFO_DEPTH));
    assign push_req      = ref_tvalid & ref_tready;
    assign pop           = dut_tvalid & ~fifo_empty;
    // At full, a same-cycle pop frees the slot the push writes into.
    assign push          = push_req & (~fifo_full | pop);
    assign overflow_evt  = push_req & fifo_full & ~pop;
    assign underflow_evt = dut_tvalid & fifo_empty;

    assign head     = mem_q[rd_ptr_q];
    assign exp_data = fifo_empty ? '0 : head[TDATA_WIDTH-1:0];
    assign exp_last = fifo_empty ? 1'b0 : head[TDATA_WIDTH];
    assign data_ok  = (dut_tdata == exp_data);
    assign last_ok  = (dut_tlast == exp_last);

    assign beat_pass     = pop & data_ok & last_ok;
    assign beat_mismatch = pop & ~data_ok;
    assign beat_tlast    = pop & data_ok & ~last_ok;
    assign beat_fail     = beat_mismatch | beat_tlast | underflow_evt;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {ref_tlast, ref_tdata};
        end
    end

    assign cnt_inc[CNT_PASS] = beat_pass;
    assign cnt_inc[CNT_FAIL] = beat_fail;
    assign cnt_inc[CNT_PKT]  = beat_pass & dut_tlast;

    // Saturating counters; clear wins over a same-cycle increment.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            assign cnt_d[gi] = clear ? '0 :
                               (cnt_inc[gi] && (cnt_q[gi] != {CNT_WIDTH{1'b1}})) ?
                               cnt_q[gi] + CNT_WIDTH'(1) : cnt_q[gi];
        end
    endgenerate

    // Flag order: {underflow, overflow, tlast, mismatch}
    assign err_evt = {underflow_evt, overflow_evt, beat_tlast, beat_mismatch};

    always_comb begin
        err_d    = clear ? '0 : (err_q | err_evt);
        ff_exp_d = ff_exp_q;
        ff_got_d = ff_got_q;
        if (clear) begin
            ff_exp_d = '0;
            ff_got_d = '0;
        end else if (beat_fail && (cnt_q[CNT_FAIL] == '0)) begin
            ff_exp_d = exp_data;
            ff_got_d = dut_tdata;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = (level_d != '0) ? ST_ACTIVE : ST_IDLE;
        end else if (err_d != '0) begin
            state_d = ST_FAIL;
        end else begin
            case (state_q)
                ST_IDLE:   if (level_d != '0) state_d = ST_ACTIVE;
                ST_ACTIVE: if (level_d == '0) state_d = ST_IDLE;
                ST_FAIL:   state_d = ST_FAIL;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            err_q    <= '0;
            ff_exp_q <= '0;
            ff_got_q <= '0;
            state_q  <= ST_IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            ff_exp_q <= ff_exp_d;
            ff_got_q <= ff_got_d;
            state_q  <= state_d;
        end
    end

    assign pass_cnt       = cnt_q[CNT_PASS];
    assign fail_cnt       = cnt_q[CNT_FAIL];
    assign pkt_cnt        = cnt_q[CNT_PKT];
    assign fifo_level     = level_q;
    assign err_mismatch   = err_q[0];
    assign err_tlast      = err_q[1];
    assign err_overflow   = err_q[2];
    assign err_underflow  = err_q[3];
    assign first_fail_exp = ff_exp_q;
    assign first_fail_got = ff_got_q;
    assign state_o        = state_q;

endmodule
